// File: rtl/rgb_fade_sequencer_if.sv
// Control/duty bundle between the switch-panel front end and the RGB fade sequencer.
interface rgb_fade_sequencer_if;
    logic        enable;
    logic        load;
    logic [1:0]  mode;
    logic [15:0] color_in;
    logic [7:0]  r_duty;
    logic [7:0]  g_duty;
    logic [7:0]  b_duty;
    logic        busy;
    logic        done;

    modport master (
        output enable, load, mode, color_in,
        input  r_duty, g_duty, b_duty, busy, done
    );

    modport slave (
        input  enable, load, mode, color_in,
        output r_duty, g_duty, b_duty, busy, done
    );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// RGB fade sequencer: ramps three pwm duty commands toward a latched RGB565 target, with optional breathe.
// Build option RGB_GAMMA_EN: registered quadratic gamma on the duty outputs, delaying all outputs one cycle.
//
// state | meaning
// IDLE  | duties forced to 0, waiting for load with enable
// RAMP  | duties step toward target once per tick (jump mode: immediate)
// HOLD  | duties held; breathe mode counts HOLD_TICKS ticks before fading
// FADE  | nonzero duties step toward 0 once per tick, then ramp back up
module rgb_fade_sequencer #(
    parameter int CLK_DIV    = 1000,
    parameter int DUTY_MAX   = 100,
    parameter int HOLD_TICKS = 50
) (
    input logic clk,
    input logic rst,
    rgb_fade_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RAMP, HOLD, FADE} seqState_t;

    localparam logic [15:0] TICK_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
    localparam logic [13:0] SCALE     = 14'(DUTY_MAX);

    seqState_t   state;
    logic [7:0]  curR, curG, curB;
    logic [7:0]  tgtR, tgtG, tgtB;
    logic [15:0] tickCnt;
    logic [15:0] holdCnt;
    logic        busyReg;
    logic        doneReg;

    logic        tick;
    logic        jumpMode;
    logic        breatheMode;
    logic [13:0] prodR, prodG, prodB;
    logic [7:0]  newR, newG, newB;
    logic [7:0]  rampR, rampG, rampB;
    logic [7:0]  fadeR, fadeG, fadeB;
    logic        rampDone;
    logic        fadeDone;

    function automatic logic [7:0] stepToward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) return cur + 8'd1;
        if (cur > tgt) return cur - 8'd1;
        return cur;
    endfunction

    function automatic logic [7:0] stepDown(input logic [7:0] cur);
        return (cur != 8'd0) ? cur - 8'd1 : cur;
    endfunction

    assign prodR = {9'd0, bus.color_in[15:11]} * SCALE;
    assign prodG = {8'd0, bus.color_in[10:5]}  * SCALE;
    assign prodB = {9'd0, bus.color_in[4:0]}   * SCALE;
    assign newR  = 8'(prodR >> 5);
    assign newG  = 8'(prodG >> 6);
    assign newB  = 8'(prodB >> 5);

    assign tick        = (state != IDLE) && (tickCnt == TICK_LAST);
    assign jumpMode    = (bus.mode == 2'd2);
    assign breatheMode = (bus.mode == 2'd1);

    assign rampR    = tick ? stepToward(curR, tgtR) : curR;
    assign rampG    = tick ? stepToward(curG, tgtG) : curG;
    assign rampB    = tick ? stepToward(curB, tgtB) : curB;
    assign fadeR    = tick ? stepDown(curR) : curR;
    assign fadeG    = tick ? stepDown(curG) : curG;
    assign fadeB    = tick ? stepDown(curB) : curB;
    assign rampDone = (rampR == tgtR) && (rampG == tgtG) && (rampB == tgtB);
    assign fadeDone = (fadeR == 8'd0) && (fadeG == 8'd0) && (fadeB == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            curR    <= 8'd0;
            curG    <= 8'd0;
            curB    <= 8'd0;
            tgtR    <= 8'd0;
            tgtG    <= 8'd0;
            tgtB    <= 8'd0;
            tickCnt <= 16'd0;
            holdCnt <= 16'd0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            tickCnt <= (!bus.enable || state == IDLE || tick) ? 16'd0 : tickCnt + 16'd1;
            doneReg <= 1'b0;
            if (!bus.enable) begin
                state   <= IDLE;
                curR    <= 8'd0;
                curG    <= 8'd0;
                curB    <= 8'd0;
                holdCnt <= 16'd0;
                busyReg <= 1'b0;
            end else if (bus.load) begin
                // A load cycle only latches the target; stepping resumes on later ticks.
                tgtR    <= newR;
                tgtG    <= newG;
                tgtB    <= newB;
                state   <= RAMP;
                holdCnt <= 16'd0;
                busyReg <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        curR    <= 8'd0;
                        curG    <= 8'd0;
                        curB    <= 8'd0;
                        busyReg <= 1'b0;
                    end
                    RAMP: begin
                        if (jumpMode) begin
                            curR    <= tgtR;
                            curG    <= tgtG;
                            curB    <= tgtB;
                            doneReg <= 1'b1;
                            state   <= HOLD;
                            busyReg <= 1'b0;
                        end else begin
                            curR <= rampR;
                            curG <= rampG;
                            curB <= rampB;
                            if (rampDone) begin
                                doneReg <= 1'b1;
                                state   <= HOLD;
                                busyReg <= 1'b0;
                            end
                        end
                    end
                    HOLD: begin
                        if (!breatheMode) begin
                            holdCnt <= 16'd0;
                        end else if (tick) begin
                            if (holdCnt == HOLD_LAST) begin
                                holdCnt <= 16'd0;
                                state   <= FADE;
                                busyReg <= 1'b1;
                            end else begin
                                holdCnt <= holdCnt + 16'd1;
                            end
                        end
                    end
                    FADE: begin
                        curR <= fadeR;
                        curG <= fadeG;
                        curB <= fadeB;
                        if (fadeDone) state <= RAMP;
                    end
                endcase
            end
        end
    end

`ifdef RGB_GAMMA_EN
    function automatic logic [7:0] gamma(input logic [7:0] v);
        logic [20:0] p;
        p = {13'd0, v} * {13'd0, v} * 21'd41;
        return 8'(p >> 12);
    endfunction

    logic [7:0] rOut, gOut, bOut;
    logic       busyOut, doneOut;

    always_ff @(posedge clk) begin
        if (rst) begin
            rOut    <= 8'd0;
            gOut    <= 8'd0;
            bOut    <= 8'd0;
            busyOut <= 1'b0;
            doneOut <= 1'b0;
        end else begin
            rOut    <= gamma(curR);
            gOut    <= gamma(curG);
            bOut    <= gamma(curB);
            busyOut <= busyReg;
            doneOut <= doneReg;
        end
    end

    assign bus.r_duty = rOut;
    assign bus.g_duty = gOut;
    assign bus.b_duty = bOut;
    assign bus.busy   = busyOut;
    assign bus.done   = doneOut;
`else
    assign bus.r_duty = curR;
    assign bus.g_duty = curG;
    assign bus.b_duty = curB;
    assign bus.busy   = busyReg;
    assign bus.done   = doneReg;
`endif
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: behavioural duty model checked every cycle, directed scenarios, random traffic.
module tb_rgb_fade_sequencer;
    localparam int CLK_DIV    = 4;
    localparam int DUTY_MAX   = 100;
    localparam int HOLD_TICKS = 3;

`ifdef RGB_GAMMA_EN
    localparam int LAT     = 1;
    localparam int R_FULL  = 92;
    localparam int G_FULL  = 96;
    localparam int R_RETGT = 9;
`else
    localparam int LAT     = 0;
    localparam int R_FULL  = 96;
    localparam int G_FULL  = 98;
    localparam int R_RETGT = 31;
`endif

    localparam int PH_IDLE = 0;
    localparam int PH_RAMP = 1;
    localparam int PH_HOLD = 2;
    localparam int PH_FADE = 3;

    logic clk;
    logic rst;
    rgb_fade_sequencer_if bus ();

    rgb_fade_sequencer #(
        .CLK_DIV   (CLK_DIV),
        .DUTY_MAX  (DUTY_MAX),
        .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nErr    = 0;
    int cyc     = 0;
    int loadCyc = 0;
    bit chkOn   = 0;

    int mCur[3];
    int mTgt[3];
    int mPhase, mRun, mHold;
    bit mBusy, mDone, tk, same;
    int eR, eG, eB;
    bit eBusy, eDone;
`ifdef RGB_GAMMA_EN
    int pR, pG, pB;
    bit pBusy, pDone;

    function automatic int gam(input int v);
        return (((v * v * 41) & 32'h1FFFFF) >> 12) & 255;
    endfunction
`endif

    function automatic int scale(input int v, input int sh);
        return (((v * DUTY_MAX) & 32'h3FFF) >> sh) & 255;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: advances on each clock edge from the inputs sampled at that edge.
    always @(posedge clk) begin
        cyc++;
`ifdef RGB_GAMMA_EN
        pR = gam(mCur[0]); pG = gam(mCur[1]); pB = gam(mCur[2]);
        pBusy = mBusy; pDone = mDone;
`endif
        if (rst) begin
            for (int i = 0; i < 3; i++) begin mCur[i] = 0; mTgt[i] = 0; end
            mPhase = PH_IDLE; mRun = 0; mHold = 0; mBusy = 0; mDone = 0;
`ifdef RGB_GAMMA_EN
            pR = 0; pG = 0; pB = 0; pBusy = 0; pDone = 0;
`endif
        end else begin
            tk = (mPhase != PH_IDLE) && (mRun % CLK_DIV == CLK_DIV - 1);
            mRun = (!bus.enable || mPhase == PH_IDLE) ? 0 : mRun + 1;
            mDone = 0;
            if (!bus.enable) begin
                for (int i = 0; i < 3; i++) mCur[i] = 0;
                mPhase = PH_IDLE; mHold = 0;
            end else if (bus.load) begin
                mTgt[0] = scale(int'(bus.color_in[15:11]), 5);
                mTgt[1] = scale(int'(bus.color_in[10:5]), 6);
                mTgt[2] = scale(int'(bus.color_in[4:0]), 5);
                mPhase = PH_RAMP; mHold = 0;
            end else if (mPhase == PH_RAMP) begin
                same = 1;
                for (int i = 0; i < 3; i++) begin
                    if (bus.mode == 2'd2) mCur[i] = mTgt[i];
                    else if (tk && mCur[i] < mTgt[i]) mCur[i]++;
                    else if (tk && mCur[i] > mTgt[i]) mCur[i]--;
                    if (mCur[i] != mTgt[i]) same = 0;
                end
                if (same) begin mDone = 1; mPhase = PH_HOLD; end
            end else if (mPhase == PH_HOLD) begin
                if (bus.mode == 2'd1) begin
                    if (tk) mHold++;
                    if (mHold == HOLD_TICKS) begin mPhase = PH_FADE; mHold = 0; end
                end else begin
                    mHold = 0;
                end
            end else if (mPhase == PH_FADE) begin
                same = 1;
                for (int i = 0; i < 3; i++) begin
                    if (tk && mCur[i] > 0) mCur[i]--;
                    if (mCur[i] != 0) same = 0;
                end
                if (same) mPhase = PH_RAMP;
            end
            mBusy = (mPhase == PH_RAMP) || (mPhase == PH_FADE);
        end
`ifdef RGB_GAMMA_EN
        eR = pR; eG = pG; eB = pB; eBusy = pBusy; eDone = pDone;
`else
        eR = mCur[0]; eG = mCur[1]; eB = mCur[2]; eBusy = mBusy; eDone = mDone;
`endif
    end

    always @(negedge clk) begin
        if (chkOn) begin
            check("r_duty", 32'(bus.r_duty), 32'(eR));
            check("g_duty", 32'(bus.g_duty), 32'(eG));
            check("b_duty", 32'(bus.b_duty), 32'(eB));
            check("busy", 32'(bus.busy), 32'(eBusy));
            check("done", 32'(bus.done), 32'(eDone));
        end
    end

    task automatic pulseLoad(input logic [15:0] c);
        @(negedge clk);
        bus.color_in = c;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        loadCyc = cyc;
    endtask

    task automatic goIdle();
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;
    endtask

    task automatic waitDone(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = cyc - loadCyc;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nDone, d1, d2;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.load = 1'b0;
        bus.mode = 2'd0;
        bus.color_in = 16'h0;
        @(negedge clk);
        chkOn = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("reset_r", 32'(bus.r_duty), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);

        // Full-white static ramp: green (98) is the slowest channel.
        bus.enable = 1'b1;
        bus.mode = 2'd0;
        pulseLoad(16'hFFFF);
        waitDone(700, lat);
        check("static_done_latency", 32'(lat), 32'(392 + LAT));
        check("static_r_final", 32'(bus.r_duty), 32'(R_FULL));
        check("static_g_final", 32'(bus.g_duty), 32'(G_FULL));
        check("static_b_final", 32'(bus.b_duty), 32'(R_FULL));
        check("static_busy_hold", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("static_done_single", 32'(bus.done), 32'd0);

        // Jump mode: pure red appears at once, one done pulse.
        goIdle();
        bus.mode = 2'd2;
        pulseLoad(16'hF800);
        nDone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cyc - loadCyc == 1 + LAT) begin
                check("jump_r", 32'(bus.r_duty), 32'(R_FULL));
                check("jump_g", 32'(bus.g_duty), 32'd0);
            end
            if (bus.done === 1'b1) nDone++;
        end
        check("jump_done_count", 32'(nDone), 32'd1);

        // Breathe on the red LSB (target 3): done every 36 cycles after the first rise at 12.
        goIdle();
        bus.mode = 2'd1;
        pulseLoad(16'h0800);
        nDone = 0; d1 = -1; d2 = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (nDone == 0) d1 = cyc - loadCyc;
                if (nDone == 1) d2 = cyc - loadCyc;
                nDone++;
            end
        end
        check("breathe_first_done", 32'(d1), 32'(12 + LAT));
        check("breathe_second_done", 32'(d2), 32'(48 + LAT));
        check("breathe_done_count", 32'(nDone), 32'd6);

        // Retarget mid-ramp: red turns around toward 31 without restarting.
        goIdle();
        bus.mode = 2'd0;
        pulseLoad(16'hFFFF);
        repeat (170) @(negedge clk);
        pulseLoad(16'h5000);
        waitDone(2000, lat);
        check("retarget_done_seen", 32'(lat >= 0), 32'd1);
        check("retarget_r_final", 32'(bus.r_duty), 32'(R_RETGT));

        // Abort mid-ramp by dropping enable.
        pulseLoad(16'hFFFF);
        repeat (50) @(negedge clk);
        bus.enable = 1'b0;
        repeat (1 + LAT) @(negedge clk);
        check("abort_r", 32'(bus.r_duty), 32'd0);
        check("abort_g", 32'(bus.g_duty), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        bus.enable = 1'b1;

        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 2999) == 0);
            bus.enable = ($urandom_range(0, 299) != 0);
            bus.load = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
            bus.color_in = 16'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.load = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end
endmodule
